// File: rtl/alimentador_instrucoes_pkg.sv
// Shared definitions for the instruction feeder: FSM state encoding, opcode
// constants and the opcode decode helper.
package alimentador_instrucoes_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EMITE  = 3'd1,
        ST_IMED   = 3'd2,
        ST_ESPERA = 3'd3,
        ST_FIM    = 3'd4
    } estado_t;

    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;

    // True when the instruction word carries a trailing immediate word
    function automatic logic eh_mvi(input logic [WORD_W-1:0] palavra);
        return palavra[OP_MSB:OP_LSB] == OP_MVI;
    endfunction

endpackage

// File: rtl/alimentador_instrucoes_memoria.sv
// Program storage: synchronous write, combinational read, no reset so the
// loaded program survives a reset of the feeder.
module memoria_programa
    import alimentador_instrucoes_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/alimentador_instrucoes.sv
// Instruction feeder: streams a loaded program word by word onto the
// processor DIN bus, pulsing Run per instruction and waiting for Done.
// Optional Done watchdog enabled by defining ALIMENTADOR_TIMEOUT_EN.
module alimentador_instrucoes
    import alimentador_instrucoes_pkg::*;
#(
    parameter  int unsigned PROG_DEPTH  = 32,
    parameter  int unsigned TIMEOUT_CYC = 16,
    localparam int unsigned AW          = $clog2(PROG_DEPTH)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [AW:0]       Len,
    input  logic              WrEn,
    input  logic [AW-1:0]     WrAddr,
    input  logic [WORD_W-1:0] WrData,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Fim,
    output logic [AW-1:0]     PC,
    output logic              Erro
);

    localparam int unsigned CW = AW + 1;

    // Reject parameter sets the addressing cannot represent
    if (TIMEOUT_CYC == 0 || PROG_DEPTH != (1 << AW)) begin : g_param_chk
        $error("alimentador_instrucoes: PROG_DEPTH must be a power of two and TIMEOUT_CYC > 0");
    end

    estado_t           estado_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     len_q;
    logic [WORD_W-1:0] din_q;
    logic              run_q;
    logic              busy_q;
    logic              fim_q;

    logic              wr_ok;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] palavra_ini;

`ifdef ALIMENTADOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          erro_q;
    assign Erro = erro_q;
`else
    assign Erro = 1'b0;
`endif

    // Loads only land while the feeder is idle
    assign wr_ok = WrEn & ~busy_q;

    memoria_programa #(.DEPTH(PROG_DEPTH)) u_memoria (
        .clk_i     (Clock),
        .wr_en_i   (wr_ok),
        .wr_addr_i (WrAddr),
        .wr_data_i (WrData),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Read address: word 0 at launch, the following word during EMITE,
    // the current PC when resuming from ESPERA
    always_comb begin
        rd_addr = cnt_q[AW-1:0];
        case (estado_q)
            ST_IDLE:  rd_addr = '0;
            ST_EMITE: rd_addr = cnt_q[AW-1:0] + AW'(1);
            default:  ;
        endcase
    end

    // A write to word 0 in the launch cycle is forwarded to the first issue
    assign palavra_ini = (wr_ok && (WrAddr == '0)) ? WrData : rd_data;

    // Sequencer with registered bus outputs; cnt_q is the unwrapped word count
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado_q <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            fim_q    <= 1'b0;
`ifdef ALIMENTADOR_TIMEOUT_EN
            tmo_q    <= '0;
            erro_q   <= 1'b0;
`endif
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    if (Start) begin
                        len_q  <= Len;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef ALIMENTADOR_TIMEOUT_EN
                        erro_q <= 1'b0;
`endif
                        if (Len != '0) begin
                            estado_q <= ST_EMITE;
                            din_q    <= palavra_ini;
                            run_q    <= 1'b1;
                        end else begin
                            estado_q <= ST_FIM;
                            fim_q    <= 1'b1;
                        end
                    end
                end
                ST_EMITE: begin
                    run_q <= 1'b0;
                    cnt_q <= cnt_q + CW'(1);
`ifdef ALIMENTADOR_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    if (eh_mvi(din_q)) begin
                        estado_q <= ST_IMED;
                        din_q    <= rd_data;
                    end else begin
                        estado_q <= ST_ESPERA;
                    end
                end
                ST_IMED: begin
                    cnt_q    <= cnt_q + CW'(1);
                    estado_q <= ST_ESPERA;
`ifdef ALIMENTADOR_TIMEOUT_EN
                    tmo_q    <= '0;
`endif
                end
                ST_ESPERA: begin
                    if (Done) begin
                        if (cnt_q >= len_q) begin
                            estado_q <= ST_FIM;
                            din_q    <= '0;
                            fim_q    <= 1'b1;
                        end else begin
                            estado_q <= ST_EMITE;
                            din_q    <= rd_data;
                            run_q    <= 1'b1;
                        end
                    end
`ifdef ALIMENTADOR_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        erro_q   <= 1'b1;
                        estado_q <= ST_FIM;
                        din_q    <= '0;
                        fim_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                ST_FIM: begin
                    fim_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= ST_IDLE;
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign DIN  = din_q;
    assign Run  = run_q;
    assign Busy = busy_q;
    assign Fim  = fim_q;
    assign PC   = cnt_q[AW-1:0];

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Scoreboard bench for alimentador_instrucoes: a program-level model pushes
// the expected issue/end events, a monitor pops them on each Run or Fim.
`timescale 1ns/1ps
module tb_alimentador_instrucoes;
    import alimentador_instrucoes_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TMO   = 16;

    logic          Clock = 1'b0;
    logic          Resetn, Start, WrEn, Done;
    logic [AW:0]   Len;
    logic [AW-1:0] WrAddr;
    logic [15:0]   WrData;
    logic [15:0]   DIN;
    logic          Run, Busy, Fim, Erro;
    logic [AW-1:0] PC;

    always #5 Clock = ~Clock;

    alimentador_instrucoes #(.PROG_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Len(Len),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Done(Done),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Fim(Fim), .PC(PC), .Erro(Erro)
    );

    typedef struct {
        bit            is_fim;
        logic [15:0]   din;
        bit            has_imm;
        logic [15:0]   imm;
        logic [AW-1:0] pc;
        bit            chk_pc;
        bit            erro;
    } exp_t;

    exp_t        sb_q[$];
    bit          plan_q[$];
    logic [15:0] mem_m [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program-level model: walk the program, consuming an extra word after mvi
    task automatic plan_run(input int len, input bit erro_fim);
        int   p;
        exp_t e;
        p = 0;
        plan_q.delete();
        if (len == 0) begin
            e = '{default: 0};
            e.is_fim = 1;
            sb_q.push_back(e);
            return;
        end
        do begin
            e = '{default: 0};
            e.din = mem_m[p % DEPTH];
            e.pc  = AW'(p % DEPTH);
            p++;
            e.has_imm = (e.din[8:6] == OP_MVI);
            if (e.has_imm) begin
                e.imm = mem_m[p % DEPTH];
                p++;
            end
            sb_q.push_back(e);
            plan_q.push_back(e.has_imm);
        end while (p < len);
        e = '{default: 0};
        e.is_fim = 1;
        e.pc     = AW'(p % DEPTH);
        e.chk_pc = 1;
        e.erro   = erro_fim;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every Run/Fim presentation against the scoreboard head
    bit          imm_pend = 0;
    logic [15:0] imm_exp;
    always @(negedge Clock) begin
        exp_t e;
        if (!Resetn) begin
            imm_pend = 0;
        end else begin
            if (imm_pend) begin
                chk("imm_din", DIN, imm_exp);
                chk("imm_run", Run, 0);
                imm_pend = 0;
            end
            if (Run || Fim) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", {Run, Fim}, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("kind", Fim, e.is_fim);
                    chk("busy", Busy, 1);
                    if (!e.is_fim) begin
                        chk("din", DIN, e.din);
                        chk("pc", PC, e.pc);
                        if (e.has_imm) begin
                            imm_pend = 1;
                            imm_exp  = e.imm;
                        end
                    end else begin
                        chk("fim_din", DIN, 0);
                        chk("fim_run", Run, 0);
                        if (e.chk_pc) chk("fim_pc", PC, e.pc);
                        chk("fim_erro", Erro, e.erro);
                    end
                end
            end
        end
    end

    task automatic load_word(input int a, input logic [15:0] w);
        WrEn   = 1;
        WrAddr = AW'(a);
        WrData = w;
        @(negedge Clock);
        WrEn = 0;
        mem_m[a] = w;
    endtask

    // Run one program acting as the processor: random Done latency, ignored
    // Done pulses outside ESPERA, and blocked write/Start noise while busy
    task automatic run_program(input int len, input bit wr0, input logic [15:0] w0);
        int w;
        if (wr0) mem_m[0] = w0;
        plan_run(len, 0);
        Start = 1;
        Len   = 6'(len);
        if (wr0) begin
            WrEn = 1; WrAddr = '0; WrData = w0;
        end
        @(negedge Clock);
        Start = 0; WrEn = 0;
`ifdef ALIMENTADOR_TIMEOUT_EN
        chk("erro_clr", Erro, 0);
`endif
        if (len == 0) begin
            chk("z_fim", Fim, 1);
            chk("z_run", Run, 0);
        end else begin
            for (int i = 0; i < plan_q.size(); i++) begin
                chk("issue", Run, 1);
                Done = 1'($urandom_range(0, 1));
                @(negedge Clock);
                if (plan_q[i]) begin
                    Done = 1'($urandom_range(0, 1));
                    @(negedge Clock);
                end
                Done = 0;
                w = $urandom_range(0, 3);
                for (int k = 0; k < w; k++) begin
                    chk("wait_quiet", {Run, Fim}, 0);
                    if ($urandom_range(0, 1) == 1) begin
                        WrEn = 1; WrAddr = AW'(3); WrData = 16'hFFFF; Start = 1;
                    end
                    @(negedge Clock);
                    WrEn = 0; Start = 0;
                end
                chk("wait_busy", Busy, 1);
                Done = 1;
                @(negedge Clock);
                Done = 0;
            end
            chk("end_fim", Fim, 1);
        end
        @(negedge Clock);
        chk("idle_busy", Busy, 0);
        chk("idle_fim", Fim, 0);
        chk("idle_din", DIN, 0);
    endtask

    // Done withheld well past the watchdog limit
    task automatic run_stall();
        load_word(0, 16'h0088);
`ifdef ALIMENTADOR_TIMEOUT_EN
        plan_run(1, 1);
`else
        plan_run(1, 0);
`endif
        Start = 1; Len = 6'd1;
        @(negedge Clock);
        Start = 0;
        chk("stall_issue", Run, 1);
        @(negedge Clock);
`ifdef ALIMENTADOR_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            chk("stall_quiet", {Run, Fim}, 0);
            @(negedge Clock);
        end
        chk("tmo_fim", Fim, 1);
        chk("tmo_erro", Erro, 1);
        @(negedge Clock);
        chk("erro_sticky", Erro, 1);
        chk("tmo_idle", Busy, 0);
`else
        for (int i = 0; i < TMO + 4; i++) begin
            chk("stall_quiet", {Run, Fim}, 0);
            @(negedge Clock);
        end
        chk("erro_tied", Erro, 0);
        Done = 1;
        @(negedge Clock);
        Done = 0;
        chk("stall_fim", Fim, 1);
        @(negedge Clock);
`endif
    endtask

    // Asynchronous reset while the immediate word is on the bus
    task automatic run_reset_imed();
        exp_t e;
        load_word(0, 16'h0040);
        load_word(1, 16'h0005);
        e = '{default: 0};
        e.din = 16'h0040; e.pc = '0; e.has_imm = 1; e.imm = 16'h0005;
        sb_q.push_back(e);
        Start = 1; Len = 6'd2;
        @(negedge Clock);
        Start = 0;
        chk("r_issue", Run, 1);
        @(negedge Clock);
        #1 Resetn = 0;
        #1;
        chk("rst_din", DIN, 0);
        chk("rst_run", Run, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_fim", Fim, 0);
        chk("rst_pc", PC, 0);
        chk("rst_erro", Erro, 0);
        @(negedge Clock);
        Resetn = 1;
        @(negedge Clock);
        run_program(2, 0, 16'h0);
    endtask

    initial begin
        logic [15:0] w;
        Resetn = 0; Start = 0; WrEn = 0; WrAddr = '0; WrData = '0; Done = 0; Len = '0;
        repeat (3) @(negedge Clock);
        Resetn = 1;
        @(negedge Clock);
        chk("reset_din", DIN, 0);
        chk("reset_run", Run, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_fim", Fim, 0);
        chk("reset_pc", PC, 0);
        chk("reset_erro", Erro, 0);

        load_word(0, 16'h0040); load_word(1, 16'h0005);
        run_program(2, 0, 16'h0);
        load_word(0, 16'h0088); load_word(1, 16'h00C8);
        run_program(2, 0, 16'h0);
        run_program(0, 0, 16'h0);

        // Full-depth program ending in mvi: the immediate wraps to word 0
        for (int a = 0; a < DEPTH; a++) begin
            case (a % 3)
                0:       w = {7'(a), OP_MV, 6'(a)};
                1:       w = {7'(a), OP_ADD, 6'(a)};
                default: w = {7'(a), OP_SUB, 6'(a)};
            endcase
            if (a == DEPTH - 1) w = {7'(a), OP_MVI, 6'(a)};
            load_word(a, w);
        end
        run_program(DEPTH, 0, 16'h0);
        run_program(DEPTH - 1, 0, 16'h0);

        run_stall();
        run_reset_imed();

        for (int a = 0; a < DEPTH; a++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[8:6] = OP_MVI;
            load_word(a, w);
        end
        for (int r = 0; r < 12; r++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w[8:6] = OP_MVI;
            run_program($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)), w);
        end
        run_program(DEPTH, 0, 16'h0);

        repeat (3) @(negedge Clock);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
